// File: rtl/cpu7_ifu_brctl.sv
// Decode-stage redirect controller: turns decode direct jumps and EX redirects
// into a single acked fetch redirect, then kills wrong-path decode slots.
module cpu7_ifu_brctl #(
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             de_valid,
  input  logic             de_jmp,
  input  logic [31:0]      de_pc,
  input  logic [31:0]      de_br_offs,
  input  logic             ex_redir_vld,
  input  logic [31:0]      ex_redir_pc,
  input  logic             redir_ack,
  output logic             redir_vld,
  output logic [31:0]      redir_pc,
  output logic             redir_src,
  output logic             de_kill,
  output logic             busy,
  output logic [CNT_W-1:0] redir_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYC - 1);

  state_t     state;
  logic [3:0] flush_cnt;
  logic       de_jump;

  assign de_jump = de_valid & de_jmp;

  // An EX redirect arriving in IDLE must also drop the younger decode slot now.
  assign de_kill = busy | ex_redir_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      redir_vld <= 1'b0;
      redir_pc  <= 32'd0;
      redir_src <= 1'b0;
      busy      <= 1'b0;
      redir_cnt <= '0;
      flush_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_redir_vld) begin
            redir_pc  <= ex_redir_pc;
            redir_src <= 1'b1;
            redir_vld <= 1'b1;
            busy      <= 1'b1;
            state     <= REQ;
          end else if (de_jump) begin
            redir_pc  <= de_pc + de_br_offs;
            redir_src <= 1'b0;
            redir_vld <= 1'b1;
            busy      <= 1'b1;
            state     <= REQ;
          end
        end

        REQ: begin
          if (redir_ack && redir_cnt != '1) begin
            redir_cnt <= redir_cnt + CNT_W'(1);
          end
          // The ack consumes the old target; a coincident EX re-arms REQ.
          if (ex_redir_vld) begin
            redir_pc  <= ex_redir_pc;
            redir_src <= 1'b1;
          end else if (redir_ack) begin
            redir_vld <= 1'b0;
            flush_cnt <= FLUSH_LOAD;
            state     <= FLUSH;
          end
        end

        FLUSH: begin
          if (ex_redir_vld) begin
            redir_pc  <= ex_redir_pc;
            redir_src <= 1'b1;
            redir_vld <= 1'b1;
            state     <= REQ;
          end else if (flush_cnt == 4'd0) begin
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end

        default: begin
          redir_vld <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu7_ifu_brctl.sv
// Bench for cpu7_ifu_brctl: transaction-level model compared every cycle,
// plus hand-computed checkpoints from the directed scenarios.
module tb_cpu7_ifu_brctl;

  localparam int FLUSH_CYC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        de_valid, de_jmp, ex_redir_vld, redir_ack;
  logic [31:0] de_pc, de_br_offs, ex_redir_pc;

  logic        redir_vld, redir_src, de_kill, busy;
  logic [31:0] redir_pc;
  logic [15:0] redir_cnt;

  logic        s_redir_vld, s_redir_src, s_de_kill, s_busy;
  logic [31:0] s_redir_pc;
  logic [1:0]  s_redir_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  cpu7_ifu_brctl #(.FLUSH_CYC(FLUSH_CYC), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .de_valid(de_valid), .de_jmp(de_jmp), .de_pc(de_pc), .de_br_offs(de_br_offs),
    .ex_redir_vld(ex_redir_vld), .ex_redir_pc(ex_redir_pc), .redir_ack(redir_ack),
    .redir_vld(redir_vld), .redir_pc(redir_pc), .redir_src(redir_src),
    .de_kill(de_kill), .busy(busy), .redir_cnt(redir_cnt)
  );

  // Narrow counter copy, used only to observe saturation.
  cpu7_ifu_brctl #(.FLUSH_CYC(FLUSH_CYC), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset),
    .de_valid(de_valid), .de_jmp(de_jmp), .de_pc(de_pc), .de_br_offs(de_br_offs),
    .ex_redir_vld(ex_redir_vld), .ex_redir_pc(ex_redir_pc), .redir_ack(redir_ack),
    .redir_vld(s_redir_vld), .redir_pc(s_redir_pc), .redir_src(s_redir_src),
    .de_kill(s_de_kill), .busy(s_busy), .redir_cnt(s_redir_cnt)
  );

  // Model: an outstanding request, the number of kill cycles left after an
  // ack, and a plain count of accepted redirects.
  bit          m_pend;
  bit          m_src;
  logic [31:0] m_tgt;
  int          m_flush_left;
  int          m_acks;

  always @(posedge clk) begin
    bit acked;
    if (reset) begin
      m_pend = 0; m_src = 0; m_tgt = 32'd0; m_flush_left = 0; m_acks = 0;
    end else begin
      acked = m_pend && redir_ack;
      if (acked) m_acks++;
      if (ex_redir_vld) begin
        m_tgt = ex_redir_pc; m_src = 1; m_pend = 1; m_flush_left = 0;
      end else if (acked) begin
        m_pend = 0; m_flush_left = FLUSH_CYC;
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (!m_pend && de_valid && de_jmp) begin
        m_tgt = de_pc + de_br_offs; m_src = 0; m_pend = 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit m_busy;
    if (checking) begin
      m_busy = m_pend || (m_flush_left > 0);
      checkOutput("redir_vld", 32'(redir_vld), 32'(m_pend));
      checkOutput("redir_pc",  redir_pc, m_tgt);
      checkOutput("redir_src", 32'(redir_src), 32'(m_src));
      checkOutput("busy",      32'(busy), 32'(m_busy));
      checkOutput("de_kill",   32'(de_kill), 32'(m_busy || ex_redir_vld));
      checkOutput("redir_cnt", 32'(redir_cnt), 32'((m_acks > 65535) ? 65535 : m_acks));
      checkOutput("redir_cnt_sat", 32'(s_redir_cnt), 32'((m_acks > 3) ? 3 : m_acks));
    end
  end

  task automatic applyStimulus(input logic dv, input logic jmp, input logic [31:0] pc,
                               input logic [31:0] offs, input logic ex,
                               input logic [31:0] expc, input logic ack);
    @(posedge clk);
    #1;
    de_valid = dv; de_jmp = jmp; de_pc = pc; de_br_offs = offs;
    ex_redir_vld = ex; ex_redir_pc = expc; redir_ack = ack;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 32'd0, 32'd0, 0, 32'd0, 0);
  endtask

  task automatic jump(input logic [31:0] pc, input logic [31:0] offs);
    applyStimulus(1, 1, pc, offs, 0, 32'd0, 0);
  endtask

  task automatic ackCycle();
    applyStimulus(0, 0, 32'd0, 32'd0, 0, 32'd0, 1);
  endtask

  task automatic exCycle(input logic [31:0] expc, input logic ack);
    applyStimulus(0, 0, 32'd0, 32'd0, 1, expc, ack);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    de_valid = 0; de_jmp = 0; de_pc = 0; de_br_offs = 0;
    ex_redir_vld = 0; ex_redir_pc = 0; redir_ack = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checking = 1'b1;

    @(negedge clk);
    checkOutput("reset_vld", 32'(redir_vld), 32'd0);
    checkOutput("reset_cnt", 32'(redir_cnt), 32'd0);

    // Ack with no request pending is ignored.
    ackCycle();
    idleCycle();
    @(negedge clk);
    checkOutput("stray_ack_cnt", 32'(redir_cnt), 32'd0);
    checkOutput("stray_ack_busy", 32'(busy), 32'd0);

    // Decode jump: target 0x1C000140, jump itself not killed.
    jump(32'h1C000100, 32'h00000040);
    @(negedge clk);
    checkOutput("jmp_capture_kill", 32'(de_kill), 32'd0);
    idleCycle();
    @(negedge clk);
    checkOutput("jmp_vld", 32'(redir_vld), 32'd1);
    checkOutput("jmp_pc", redir_pc, 32'h1C000140);
    checkOutput("jmp_src", 32'(redir_src), 32'd0);
    idleCycle();
    idleCycle();
    ackCycle();
    idleCycle();
    @(negedge clk);
    checkOutput("flush1_kill", 32'(de_kill), 32'd1);
    checkOutput("flush1_vld", 32'(redir_vld), 32'd0);
    ackCycle();
    @(negedge clk);
    checkOutput("flush2_kill", 32'(de_kill), 32'd1);
    idleCycle();
    @(negedge clk);
    checkOutput("post_flush_kill", 32'(de_kill), 32'd0);
    checkOutput("jmp_cnt", 32'(redir_cnt), 32'd1);

    // Negative offset wraps modulo 2^32.
    jump(32'h00000004, 32'hFFFFFFF8);
    idleCycle();
    @(negedge clk);
    checkOutput("wrap_pc", redir_pc, 32'hFFFFFFFC);
    ackCycle();
    repeat (3) idleCycle();

    // EX beats a same-cycle decode jump.
    applyStimulus(1, 1, 32'h00001000, 32'h00001000, 1, 32'h00008000, 0);
    @(negedge clk);
    checkOutput("prio_kill", 32'(de_kill), 32'd1);
    idleCycle();
    @(negedge clk);
    checkOutput("prio_pc", redir_pc, 32'h00008000);
    checkOutput("prio_src", 32'(redir_src), 32'd1);
    ackCycle();
    repeat (3) idleCycle();
    @(negedge clk);
    checkOutput("prio_single", 32'(redir_cnt), 32'd3);
    checkOutput("prio_idle", 32'(busy), 32'd0);

    // EX override of a pending decode target.
    jump(32'h00001000, 32'h00001000);
    idleCycle();
    @(negedge clk);
    checkOutput("ovr_pre_pc", redir_pc, 32'h00002000);
    exCycle(32'h00009000, 0);
    idleCycle();
    @(negedge clk);
    checkOutput("ovr_pc", redir_pc, 32'h00009000);
    checkOutput("ovr_src", 32'(redir_src), 32'd1);
    ackCycle();
    idleCycle();
    @(negedge clk);
    checkOutput("ovr_flush_vld", 32'(redir_vld), 32'd0);
    checkOutput("ovr_cnt", 32'(redir_cnt), 32'd4);
    repeat (2) idleCycle();

    // Ack and EX collide: count the ack, stay in REQ with the new target.
    jump(32'h00001000, 32'h00003000);
    idleCycle();
    exCycle(32'h0000A000, 1);
    idleCycle();
    @(negedge clk);
    checkOutput("coll_vld", 32'(redir_vld), 32'd1);
    checkOutput("coll_pc", redir_pc, 32'h0000A000);
    checkOutput("coll_cnt", 32'(redir_cnt), 32'd5);
    ackCycle();
    exCycle(32'h0000B000, 0);
    @(negedge clk);
    checkOutput("flush_ex_vld", 32'(redir_vld), 32'd0);
    idleCycle();
    @(negedge clk);
    checkOutput("flush_ex_pc", redir_pc, 32'h0000B000);
    checkOutput("flush_ex_vld2", 32'(redir_vld), 32'd1);

    // Reset while a request is pending.
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_vld", 32'(redir_vld), 32'd0);
    checkOutput("rst_pc", redir_pc, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_kill", 32'(de_kill), 32'd0);
    checkOutput("rst_cnt", 32'(redir_cnt), 32'd0);

    // Five acked redirects saturate a 2-bit counter at 3.
    for (int i = 1; i <= 5; i++) begin
      jump(32'(i) << 8, 32'h00000010);
      idleCycle();
      ackCycle();
      repeat (3) idleCycle();
    end
    @(negedge clk);
    checkOutput("sat_cnt16", 32'(redir_cnt), 32'd5);
    checkOutput("sat_cnt2", 32'(s_redir_cnt), 32'd3);

    repeat (2) idleCycle();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu7_ifu_brctl.md
Name: cpu7_ifu_brctl

Overview:
- Redirect controller for the IFU decode stage.
- Takes decode-resolved direct jumps: the PC plus the sign-extended, pre-shifted branch offset from the immediate decoder. Also takes backend (EX) redirects.
- Issues a single fetch redirect with a valid/ack handshake, then kills wrong-path decode slots for a programmable number of cycles.
- Sits between the decode-stage immediate/offset logic and the fetch PC generator.

Parameters:
- FLUSH_CYC, 2, cycles of decode kill after redirect ack; legal range 1..15.
- CNT_W, 16, width of the saturating redirect performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- de_valid  in  1  decode slot holds a valid instruction
- de_jmp  in  1  decoded instruction is a direct unconditional jump (b/bl class)
- de_pc  in  32  PC of decode-slot instruction
- de_br_offs  in  32  sign-extended byte offset, low 2 bits zero
- ex_redir_vld  in  1  backend redirect request (mispredict/exception), single-cycle pulse
- ex_redir_pc  in  32  backend redirect target
- redir_ack  in  1  fetch accepted redirect this cycle
- redir_vld  out  1  redirect request to fetch
- redir_pc  out  32  redirect target
- redir_src  out  1  0=decode jump, 1=EX
- de_kill  out  1  drop decode-slot instruction this cycle
- busy  out  1  controller not IDLE
- redir_cnt  out  CNT_W  count of acked redirects, saturating

Behaviour:
- States: IDLE, REQ, FLUSH. Reset values:
  - state=IDLE
  - redir_vld=0, redir_pc=0, redir_src=0
  - de_kill=0, busy=0
  - redir_cnt=0
  - flush counter=0
- Reset mid-operation aborts any pending request in the same edge. No redirect is issued after reset until a new request arrives.
- IDLE:
  - ex_redir_vld=1: latch ex_redir_pc, src=1, go REQ.
  - Else if de_valid & de_jmp: latch de_pc+de_br_offs (32-bit modular add, carry discarded), src=0, go REQ.
  - EX has priority when both arrive in the same cycle; the decode jump is dropped.
- REQ:
  - redir_vld=1; redir_pc and redir_src come from registered state. Latency from request capture to redir_vld is exactly 1 cycle.
  - redir_pc/redir_src hold stable while redir_vld=1 & !redir_ack, except on EX override.
  - ex_redir_vld=1 in REQ: replace target with ex_redir_pc and set src=1 at the next edge. This applies regardless of the current src.
  - If ex_redir_vld and redir_ack occur in the same cycle, the ack consumes the old target. The EX target is captured and the state returns to REQ (not FLUSH). redir_cnt still increments.
  - redir_ack without EX: go FLUSH, load counter with FLUSH_CYC-1, redir_cnt+=1 (holds at all-ones).
  - Decode jumps arriving in REQ are ignored; they are wrong-path.
- FLUSH:
  - redir_vld=0.
  - Counter decrements each cycle; at 0, go IDLE next edge. FLUSH therefore lasts exactly FLUSH_CYC cycles.
  - ex_redir_vld=1 in FLUSH: capture target, go REQ, abandon the counter.
  - Decode jumps are ignored.
- de_kill:
  - Registered-state decode: 1 in REQ and FLUSH, 0 in IDLE.
  - Additionally, de_kill is combinationally asserted in IDLE during the cycle ex_redir_vld=1, so the younger decode instruction is dropped.
  - A decode jump that triggers REQ is not itself killed; it completes, since bl must write the link register.
- busy = (state != IDLE).
- redir_ack while redir_vld=0 is ignored and must not advance state or the counter.
- The redir_pc[1:0] alignment check is owned by fetch, not this block.

Test Plan:
- Decode jump: de_pc=0x1C000100, de_br_offs=0x00000040, de_jmp=1 in IDLE. Required: next cycle redir_vld=1, redir_pc=0x1C000140, src=0. Ack 3 cycles later; de_kill high through REQ plus 2 FLUSH cycles; redir_cnt=1.
- Negative offset wrap: de_pc=0x00000004, de_br_offs=0xFFFFFFF8. Required: redir_pc=0xFFFFFFFC.
- Same-cycle priority: decode jump (target 0x2000) and ex_redir_vld with 0x8000. Required: redir_pc=0x8000, src=1, de_kill=1 in the capture cycle, only one redirect issued.
- EX override in REQ: REQ holding decode target 0x2000, ex_redir_vld with 0x9000, no ack. Required: next cycle redir_pc=0x9000, src=1. Ack then drives FLUSH; redir_cnt=1.
- Ack+EX collision: ack and ex_redir_vld (0xA000) in the same cycle. Required: redir_cnt+1, state remains REQ, redir_pc=0xA000 next cycle. Then EX in FLUSH (0xB000) returns to REQ immediately.
- Reset mid-REQ: reset asserted while redir_vld=1. Required: next cycle all outputs 0, state IDLE. With CNT_W=2 and 5 acked redirects: redir_cnt saturates at 3.
